// File: rtl/mips_pkg.sv
// Shared encodings for the MIPS memory stage: access sizes, memory FSM states
// and the alignment rule used by the lane aligner.
package mips_pkg;

    localparam logic [1:0] DS_WORD = 2'b00;
    localparam logic [1:0] DS_HALF = 2'b01;
    localparam logic [1:0] DS_BYTE = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FAULT = 2'd2
    } mem_state_t;

    // Dsize 2'b11 falls into the word rule.
    function automatic logic addr_misaligned(input logic [1:0] dsize, input logic [1:0] offset);
        case (dsize)
            DS_BYTE: addr_misaligned = 1'b0;
            DS_HALF: addr_misaligned = offset[0];
            default: addr_misaligned = (offset != 2'b00);
        endcase
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Big-endian byte-lane steering: store enables/replicated data and load lane
// extraction with sign or zero extension. Purely combinational.
module mem_lane_align
    import mips_pkg::*;
(
    input  logic [1:0]  dsize,
    input  logic [1:0]  offset,
    input  logic [31:0] store_data,
    input  logic        load_ext,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [7:0]  byte_lane;
    logic [15:0] half_lane;

    always_comb begin
        be         = 4'b1111;
        wdata      = store_data;
        load_data  = rdata;
        byte_lane  = 8'h00;
        half_lane  = 16'h0000;
        misaligned = addr_misaligned(dsize, offset);

        case (dsize)
            DS_BYTE: begin
                be    = 4'b1000 >> offset;
                wdata = {4{store_data[7:0]}};
                // Offset 0 is the most significant byte.
                case (offset)
                    2'd0:    byte_lane = rdata[31:24];
                    2'd1:    byte_lane = rdata[23:16];
                    2'd2:    byte_lane = rdata[15:8];
                    default: byte_lane = rdata[7:0];
                endcase
                load_data = load_ext ? {{24{byte_lane[7]}}, byte_lane}
                                     : {24'h000000, byte_lane};
            end
            DS_HALF: begin
                be        = offset[1] ? 4'b0011 : 4'b1100;
                wdata     = {2{store_data[15:0]}};
                half_lane = offset[1] ? rdata[15:0] : rdata[31:16];
                load_data = load_ext ? {{16{half_lane[15]}}, half_lane}
                                     : {16'h0000, half_lane};
            end
            default: begin
                be        = 4'b1111;
                wdata     = store_data;
                load_data = rdata;
            end
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS pipeline: EX/MEM register, req/ack data-memory
// controller with misalignment and timeout aborts, and the MEM/WB register.
module mem_stage
    import mips_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWr,
    input  logic        MemtoReg,
    input  logic        RegWr,
    input  logic        Branch,
    input  logic        Zero,
    input  logic        Jump,
    input  logic        Jal,
    input  logic        Loadext,
    input  logic [1:0]  Dsize,
    input  logic [31:0] ALUout,
    input  logic [31:0] BusB,
    input  logic [31:0] BranchTarget,
    input  logic [31:0] Delayslot2,
    input  logic [4:0]  Rw,
    output logic        stall,
    output logic        take_branch,
    output logic        take_jump,
    output logic [31:0] branch_target,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        wb_RegWr,
    output logic [4:0]  wb_Rw,
    output logic [31:0] wb_data,
    output logic        mem_fault,
    output logic [31:0] fault_addr
);

    logic        m_MemWr, m_MemtoReg, m_RegWr, m_Branch, m_Zero, m_Jump, m_Jal, m_Loadext;
    logic [1:0]  m_Dsize;
    logic [31:0] m_ALUout, m_BusB, m_BranchTarget, m_Delayslot2;
    logic [4:0]  m_Rw;

    mem_state_t       state, next_state;
    logic [CNT_W-1:0] cnt, cnt_next;

    logic        mem_op, ack_ok, wb_load, wb_fault;
    logic [3:0]  al_be;
    logic [31:0] al_wdata, load_data, wb_next;
    logic        misaligned;

    // ---- EX/MEM register ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_MemWr        <= 1'b0;
            m_MemtoReg     <= 1'b0;
            m_RegWr        <= 1'b0;
            m_Branch       <= 1'b0;
            m_Zero         <= 1'b0;
            m_Jump         <= 1'b0;
            m_Jal          <= 1'b0;
            m_Loadext      <= 1'b0;
            m_Dsize        <= 2'b00;
            m_ALUout       <= 32'h0;
            m_BusB         <= 32'h0;
            m_BranchTarget <= 32'h0;
            m_Delayslot2   <= 32'h0;
            m_Rw           <= 5'd0;
        end else if (!stall) begin
            m_MemWr        <= MemWr;
            m_MemtoReg     <= MemtoReg;
            m_RegWr        <= RegWr;
            m_Branch       <= Branch;
            m_Zero         <= Zero;
            m_Jump         <= Jump;
            m_Jal          <= Jal;
            m_Loadext      <= Loadext;
            m_Dsize        <= Dsize;
            m_ALUout       <= ALUout;
            m_BusB         <= BusB;
            m_BranchTarget <= BranchTarget;
            m_Delayslot2   <= Delayslot2;
            m_Rw           <= Rw;
        end
    end

    assign mem_op        = m_MemWr | m_MemtoReg;
    assign take_branch   = m_Branch & m_Zero;
    assign take_jump     = m_Jump;
    assign branch_target = m_BranchTarget;

    mem_lane_align u_align (
        .dsize      (m_Dsize),
        .offset     (m_ALUout[1:0]),
        .store_data (m_BusB),
        .load_ext   (m_Loadext),
        .rdata      (dmem_rdata),
        .be         (al_be),
        .wdata      (al_wdata),
        .load_data  (load_data),
        .misaligned (misaligned)
    );

    // ---- memory access FSM ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
        end
    end

    // cnt holds the number of request cycles already spent without ack.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        dmem_req   = 1'b0;
        ack_ok     = 1'b0;
        wb_load    = 1'b0;
        wb_fault   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!mem_op) begin
                    wb_load = 1'b1;
                end else if (misaligned) begin
                    next_state = ST_FAULT;
                end else begin
                    dmem_req = 1'b1;
                    if (dmem_ack) begin
                        ack_ok  = 1'b1;
                        wb_load = 1'b1;
                    end else if (TIMEOUT <= 1) begin
                        next_state = ST_FAULT;
                    end else begin
                        next_state = ST_WAIT;
                        cnt_next   = CNT_W'(1);
                    end
                end
            end
            ST_WAIT: begin
                dmem_req = 1'b1;
                if (dmem_ack) begin
                    ack_ok     = 1'b1;
                    wb_load    = 1'b1;
                    next_state = ST_IDLE;
                    cnt_next   = '0;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    next_state = ST_FAULT;
                end else begin
                    cnt_next = cnt + CNT_W'(1);
                end
            end
            ST_FAULT: begin
                wb_load    = 1'b1;
                wb_fault   = 1'b1;
                next_state = ST_IDLE;
                cnt_next   = '0;
            end
            default: begin
                next_state = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    assign stall      = mem_op & ~ack_ok & (state != ST_FAULT);
    assign mem_fault  = (state == ST_FAULT);
    assign dmem_we    = m_MemWr & dmem_req;
    assign dmem_be    = dmem_req ? al_be : 4'b0000;
    assign dmem_wdata = m_MemWr ? al_wdata : 32'h0;
    assign dmem_addr  = {m_ALUout[31:2], 2'b00};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fault_addr <= 32'h0;
        end else if (state == ST_FAULT) begin
            fault_addr <= m_ALUout;
        end
    end

    assign wb_next = m_Jal      ? m_Delayslot2 :
                     m_MemtoReg ? load_data    : m_ALUout;

    // ---- MEM/WB register ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_RegWr <= 1'b0;
            wb_Rw    <= 5'd0;
            wb_data  <= 32'h0;
        end else if (wb_load) begin
            wb_RegWr <= m_RegWr & ~wb_fault;
            wb_Rw    <= m_Rw;
            wb_data  <= wb_next;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected writebacks are queued at issue and
// compared when the instruction retires; a small responder answers dmem requests.
module tb_mem_stage;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        MemWr, MemtoReg, RegWr, Branch, Zero, Jump, Jal, Loadext;
    logic [1:0]  Dsize;
    logic [31:0] ALUout, BusB, BranchTarget, Delayslot2;
    logic [4:0]  Rw;
    logic        stall, take_branch, take_jump;
    logic [31:0] branch_target;
    logic        dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  dmem_be;
    logic        dmem_ack;
    logic        wb_RegWr;
    logic [4:0]  wb_Rw;
    logic [31:0] wb_data;
    logic        mem_fault;
    logic [31:0] fault_addr;

    typedef struct {
        logic        regwr;
        logic [4:0]  rw;
        logic [31:0] data;
        logic        chk_data;
    } wb_exp_t;

    wb_exp_t sb[$];

    int tests = 0;
    int fails = 0;
    int reqs, stalls, faults;
    logic        seen_we;
    logic [3:0]  seen_be;
    logic [31:0] seen_addr, seen_wdata;

    mem_stage #(.TIMEOUT(TO), .CNT_W(3)) dut (
        .clk(clk), .reset(reset),
        .MemWr(MemWr), .MemtoReg(MemtoReg), .RegWr(RegWr), .Branch(Branch),
        .Zero(Zero), .Jump(Jump), .Jal(Jal), .Loadext(Loadext), .Dsize(Dsize),
        .ALUout(ALUout), .BusB(BusB), .BranchTarget(BranchTarget),
        .Delayslot2(Delayslot2), .Rw(Rw),
        .stall(stall), .take_branch(take_branch), .take_jump(take_jump),
        .branch_target(branch_target),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack),
        .wb_RegWr(wb_RegWr), .wb_Rw(wb_Rw), .wb_data(wb_data),
        .mem_fault(mem_fault), .fault_addr(fault_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        MemWr = 0; MemtoReg = 0; RegWr = 0; Branch = 0; Zero = 0; Jump = 0;
        Jal = 0; Loadext = 0; Dsize = 2'b00; ALUout = 0; BusB = 0;
        BranchTarget = 0; Delayslot2 = 0; Rw = 0;
    endtask

    task automatic push_exp(input logic regwr, input logic [4:0] rw,
                            input logic [31:0] data, input logic chk_data);
        wb_exp_t e;
        e.regwr = regwr; e.rw = rw; e.data = data; e.chk_data = chk_data;
        sb.push_back(e);
    endtask

    // Inputs for the op must already be driven (at a negedge) before calling.
    task automatic run_op(input string tag, input int ack_at, input logic [31:0] rdata);
        wb_exp_t e;
        logic done;
        done = 1'b0;
        reqs = 0; stalls = 0; faults = 0;
        seen_we = 0; seen_be = 0; seen_addr = 0; seen_wdata = 0;
        @(posedge clk);
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk);
            dmem_ack = 1'b0;
            if (dmem_req) begin
                reqs++;
                seen_we = dmem_we; seen_be = dmem_be;
                seen_addr = dmem_addr; seen_wdata = dmem_wdata;
                if (reqs == ack_at) begin
                    dmem_ack   = 1'b1;
                    dmem_rdata = rdata;
                end
            end
            #1;
            if (mem_fault) faults++;
            if (!stall) begin
                done = 1'b1;
                clear_inputs();
                @(posedge clk);
                #1;
                dmem_ack = 1'b0;
                break;
            end
            stalls++;
        end
        if (!done) begin
            check({tag, " retire"}, 32'd0, 32'd1);
        end else if (sb.size() == 0) begin
            check({tag, " scoreboard"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({tag, " wb_RegWr"}, 32'(wb_RegWr), 32'(e.regwr));
            check({tag, " wb_Rw"}, 32'(wb_Rw), 32'(e.rw));
            if (e.chk_data) check({tag, " wb_data"}, wb_data, e.data);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        dmem_ack = 1'b0;
        dmem_rdata = 32'h0;
        clear_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst ctrl", {26'd0, stall, take_branch, take_jump, dmem_req, dmem_we, mem_fault}, 32'd0);
        check("rst wb", {26'd0, wb_RegWr, wb_Rw}, 32'd0);
        check("rst data", wb_data | dmem_addr | dmem_wdata | fault_addr | branch_target | 32'(dmem_be), 32'd0);
        reset = 1'b0;

        // ALU op, no memory
        @(negedge clk);
        ALUout = 32'h1234; RegWr = 1; Rw = 5;
        push_exp(1, 5, 32'h1234, 1);
        run_op("alu", 0, 32'h0);
        check("alu stalls", 32'(stalls), 0);
        check("alu reqs", 32'(reqs), 0);

        // Signed byte load, ack on 4th request cycle
        @(negedge clk);
        MemtoReg = 1; RegWr = 1; Rw = 7; Loadext = 1; Dsize = 2'b10; ALUout = 32'h1001;
        push_exp(1, 7, 32'hFFFF_FFF0, 1);
        run_op("lb", 4, 32'h11F0_22AB);
        check("lb stalls", 32'(stalls), 3);
        check("lb be", 32'(seen_be), 32'b0100);
        check("lb we", 32'(seen_we), 0);
        check("lb addr", seen_addr, 32'h1000);

        // Half store, zero-wait
        @(negedge clk);
        MemWr = 1; Dsize = 2'b01; BusB = 32'hCAFE_BEEF; ALUout = 32'h2002;
        push_exp(0, 0, 32'h2002, 1);
        run_op("sh", 1, 32'h0);
        check("sh we", 32'(seen_we), 1);
        check("sh be", 32'(seen_be), 32'b0011);
        check("sh wdata", seen_wdata, 32'hBEEF_BEEF);
        check("sh addr", seen_addr, 32'h2000);
        check("sh stalls", 32'(stalls), 0);

        // Unsigned half load, upper address half
        @(negedge clk);
        MemtoReg = 1; RegWr = 1; Rw = 9; Loadext = 0; Dsize = 2'b01; ALUout = 32'h2002;
        push_exp(1, 9, 32'h0000_ABCD, 1);
        run_op("lhu", 2, 32'h1234_ABCD);
        check("lhu stalls", 32'(stalls), 1);

        // Byte store at offset 3
        @(negedge clk);
        MemWr = 1; Dsize = 2'b10; BusB = 32'h0000_00A5; ALUout = 32'h4003;
        push_exp(0, 0, 32'h4003, 1);
        run_op("sb", 1, 32'h0);
        check("sb be", 32'(seen_be), 32'b0001);
        check("sb wdata", seen_wdata, 32'hA5A5_A5A5);

        // Dsize 11 behaves as an aligned word load
        @(negedge clk);
        MemtoReg = 1; RegWr = 1; Rw = 10; Loadext = 1; Dsize = 2'b11; ALUout = 32'h5000;
        push_exp(1, 10, 32'hDEAD_BEEF, 1);
        run_op("lw11", 2, 32'hDEAD_BEEF);
        check("lw11 be", 32'(seen_be), 32'b1111);

        // Misaligned word load
        @(negedge clk);
        MemtoReg = 1; RegWr = 1; Rw = 3; Dsize = 2'b00; ALUout = 32'h3002;
        push_exp(0, 3, 32'h0, 0);
        run_op("mis", 1, 32'h0);
        check("mis reqs", 32'(reqs), 0);
        check("mis faults", 32'(faults), 1);
        check("mis stalls", 32'(stalls), 1);
        check("mis fault_addr", fault_addr, 32'h3002);

        // No ack: timeout abort
        @(negedge clk);
        MemtoReg = 1; RegWr = 1; Rw = 12; Dsize = 2'b00; ALUout = 32'h6000;
        push_exp(0, 12, 32'h0, 0);
        run_op("tmo", 0, 32'h0);
        check("tmo reqs", 32'(reqs), TO);
        check("tmo stalls", 32'(stalls), TO);
        check("tmo faults", 32'(faults), 1);
        check("tmo fault_addr", fault_addr, 32'h6000);

        // Ack on the timeout edge wins
        @(negedge clk);
        MemtoReg = 1; RegWr = 1; Rw = 13; Dsize = 2'b00; ALUout = 32'h6004;
        push_exp(1, 13, 32'h0BAD_F00D, 1);
        run_op("ackto", TO, 32'h0BAD_F00D);
        check("ackto reqs", 32'(reqs), TO);
        check("ackto faults", 32'(faults), 0);

        // Jal writes the link address
        @(negedge clk);
        Jal = 1; RegWr = 1; Rw = 31; Delayslot2 = 32'h88; ALUout = 32'h55;
        push_exp(1, 31, 32'h88, 1);
        run_op("jal", 0, 32'h0);

        // Branch / jump redirection
        @(negedge clk);
        Branch = 1; Zero = 1; BranchTarget = 32'h400;
        @(posedge clk); #1;
        check("br taken", 32'(take_branch), 1);
        check("br target", branch_target, 32'h400);
        @(negedge clk);
        clear_inputs();
        Branch = 1; Zero = 0; Jump = 1;
        @(posedge clk); #1;
        check("br not taken", 32'(take_branch), 0);
        check("jump", 32'(take_jump), 1);

        // Reset in the middle of a waiting access
        @(negedge clk);
        clear_inputs();
        MemtoReg = 1; RegWr = 1; Rw = 4; ALUout = 32'h7000;
        Branch = 1; Zero = 1; BranchTarget = 32'h400;
        @(posedge clk);
        @(negedge clk);
        dmem_ack = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("wait req", {30'd0, dmem_req, stall}, 32'b11);
        #2 reset = 1'b1;
        #1;
        check("arst req/stall", {30'd0, dmem_req, stall}, 32'd0);
        check("arst branch", 32'(take_branch) | branch_target, 32'd0);
        check("arst wb", {26'd0, wb_RegWr, wb_Rw} | wb_data | fault_addr, 32'd0);
        clear_inputs();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Consumer side of the execute-stage output bundle: the EX/MEM pipeline register, the data-memory access controller and the MEM/WB pipeline register of the 5-stage MIPS pipeline.
- Captures the EX results and resolves branch/jump redirection.
- Drives a req/ack data-memory port with byte-lane stores and sized, extended loads.
- Stalls the upstream pipeline while an access is outstanding, and aborts misaligned or timed-out accesses.

Parameters:
- TIMEOUT, 16: maximum cycles a dmem request may wait for ack before it is aborted; minimum 1.
- CNT_W, 5: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  pipeline clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- MemWr  in  1  store operation in EX.
- MemtoReg  in  1  load operation in EX.
- RegWr  in  1  register writeback enable.
- Branch  in  1  conditional branch.
- Zero  in  1  ALU zero flag.
- Jump  in  1  jump.
- Jal  in  1  link writeback.
- Loadext  in  1  1 = sign-extend sub-word loads, 0 = zero-extend.
- Dsize  in  2  access size: 00 word, 01 half, 10 byte, 11 treated as word.
- ALUout  in  32  effective address or ALU result.
- BusB  in  32  store data.
- BranchTarget  in  32  branch target address.
- Delayslot2  in  32  link address.
- Rw  in  5  destination register.
- stall  out  1  holds EX/ID/IF while high.
- take_branch  out  1  Branch & Zero, from the M register.
- take_jump  out  1  Jump, from the M register.
- branch_target  out  32  BranchTarget, from the M register.
- dmem_req  out  1  access request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word address, {ALUout[31:2], 2'b00}.
- dmem_be  out  4  byte enables; bit 3 = bits [31:24].
- dmem_wdata  out  32  lane-replicated store data.
- dmem_rdata  in  32  read data, valid with ack.
- dmem_ack  in  1  access complete, single-cycle pulse.
- wb_RegWr  out  1  writeback enable.
- wb_Rw  out  5  writeback register.
- wb_data  out  32  result: load data, link address or ALU result.
- mem_fault  out  1  one-cycle pulse when an access is aborted.
- fault_addr  out  32  ALUout of the most recent faulted access.

Behaviour:
- Reset (async): all M and WB registers, the state and the counter clear to 0. With zero control fields the stage holds a bubble, so every output reads 0. Reset mid-access drops dmem_req immediately.
- M register: loads every input on a rising edge when stall == 0, and holds when stall == 1.
- Classification: mem_op = m_MemWr | m_MemtoReg.
- Alignment: a half access is misaligned when addr[0] == 1. A word access (Dsize 00 or 11) is misaligned when addr[1:0] != 0.
- Endianness: big-endian. Byte offset 0 maps to bits [31:24].
- Store lanes:
  - byte: be = 1000 >> off; wdata = {4{BusB[7:0]}}.
  - half: be = 1100 (off 0) or 0011 (off 2); wdata = {2{BusB[15:0]}}.
  - word: be = 1111; wdata = BusB.
- Loads: dmem_be is set as for stores. The selected lane is right-justified, then sign- or zero-extended per m_Loadext. Word loads pass through unchanged.
- FSM states:
  - IDLE:
    - Non-mem op: stall = 0; WB loads at the next edge (MEM latency 1 cycle).
    - Aligned mem op: dmem_req = 1 combinationally in the same cycle, and the state moves to WAIT.
    - Misaligned mem op: no request; go to FAULT.
  - WAIT:
    - dmem_req = 1 and stall = 1 until ack.
    - If dmem_ack is high at an edge: WB loads, stall drops, and the state returns to IDLE.
    - Zero-wait: if ack arrives in the first request cycle, the FSM stays in IDLE and the access completes in 1 cycle.
    - The counter increments each WAIT cycle. When count == TIMEOUT with no ack, go to FAULT.
  - FAULT: lasts 1 cycle.
    - mem_fault = 1; fault_addr <= m_ALUout.
    - WB loads with wb_RegWr forced to 0.
    - stall = 0; the counter clears; return to IDLE.
- stall equation: stall = mem_op & ~dmem_ack & ~(state == FAULT). A misaligned op in IDLE also stalls for exactly 1 cycle.
- WB select priority: m_Jal gives Delayslot2, else m_MemtoReg gives load data, else ALUout. wb_RegWr = m_RegWr, except on fault.
- Simultaneous ack and timeout in the same cycle: ack wins and the access completes normally.
- Edge cases: ack outside WAIT/IDLE-mem is ignored. Branch outputs stay stable while stalled, so downstream must sample them once.

Decomposition:
- Shared package mips_pkg:
  - Dsize encodings: DS_WORD = 2'b00, DS_HALF = 2'b01, DS_BYTE = 2'b10.
  - FSM state constants: ST_IDLE, ST_WAIT, ST_FAULT.
- One sub-module, mem_lane_align (combinational), handles be/wdata generation for stores and load extraction/extension. It is reused by future cache logic.

Test Plan:
- ALU op, no memory: ALUout = 0x1234, RegWr = 1, Rw = 5 → one cycle later wb_data = 0x1234, wb_Rw = 5, stall never asserted.
- Byte load, Loadext = 1, ALUout = 0x1001, rdata = 0x11F022AB, ack after 3 cycles → dmem_be = 0100, stall high 3 cycles, wb_data = 0xFFFFFFF0.
- Half store, BusB = 0xCAFEBEEF, ALUout = 0x2002, zero-wait ack → dmem_we = 1, be = 0011, wdata = 0xBEEFBEEF, addr = 0x2000, no stall.
- Misaligned word load at 0x3002 → no dmem_req, mem_fault pulse, fault_addr = 0x3002, wb_RegWr = 0, stall 1 cycle.
- No ack, TIMEOUT = 4 → req held 4 cycles then mem_fault; ack arriving with the timeout edge instead completes normally.
- Branch = 1, Zero = 1, BranchTarget = 0x400 → take_branch = 1, branch_target = 0x400; reset asserted mid-WAIT → dmem_req and stall drop asynchronously, all outputs 0.
